// File: rtl/bus_mmu_n.sv
// Bus decode / MMU between the core load/store path and NCH slave blocks.
// A master request is decoded against NCH base/mask regions (lowest index
// wins on overlap), forwarded to the selected slave with a registered
// one-hot select and region offset, and answered with a one-cycle m_ready
// strobe. Unmapped addresses and slaves that never respond (timeout) are
// reported through m_err.
//
// Handshake: the master raises m_req with m_addr/m_we/m_wdata stable; the
// unit samples it only in IDLE and answers with exactly one m_ready cycle
// carrying m_rdata/m_err. A slave completes by pulsing its s_ready bit while
// its s_sel bit is high; s_ready on any other channel is ignored.
module bus_mmu_n #(
  parameter int                 NCH         = 3,
  parameter int                 AW          = 32,
  parameter int                 DW          = 32,
  parameter logic [NCH*AW-1:0]  REGION_BASE = {32'h2000, 32'h1000, 32'h0000},
  parameter logic [NCH*AW-1:0]  REGION_MASK = {32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFF000},
  parameter int                 TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [AW-1:0]     m_addr,
  input  logic [DW-1:0]     m_wdata,
  output logic              m_ready,
  output logic [DW-1:0]     m_rdata,
  output logic              m_err,
  output logic [NCH-1:0]    s_sel,
  output logic              s_we,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic [NCH-1:0]    s_ready,
  input  logic [NCH*DW-1:0] s_rdata,
  output logic [NCH*16-1:0] hit_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            m_ready_q, m_ready_d;
  logic            m_err_q, m_err_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic [NCH-1:0]  s_sel_q, s_sel_d;
  logic            s_we_q, s_we_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     hit_q [NCH];
  logic [15:0]     hit_d [NCH];

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [AW-1:0]   dec_off;
  logic            sel_ready;
  logic [DW-1:0]   sel_rdata;
  logic            timeout_hit;

  // Address decode: scan from the top so the lowest matching channel wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((m_addr & REGION_MASK[i*AW +: AW]) ==
          (REGION_BASE[i*AW +: AW] & REGION_MASK[i*AW +: AW])) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
        dec_off = m_addr & ~REGION_MASK[i*AW +: AW];
      end
    end
  end

  // Pick the ready/rdata of the latched channel only; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == IW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP FSM.
  always_comb begin
    state_d   = state_q;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
    m_rdata_d = m_rdata_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < NCH; i++) hit_d[i] = hit_q[i];

    case (state_q)
      IDLE: begin
        if (m_req) begin
          if (dec_hit) begin
            ch_d      = dec_idx;
            s_sel_d   = NCH'(1) << dec_idx;
            s_we_d    = m_we;
            s_addr_d  = dec_off;
            s_wdata_d = m_wdata;
            cnt_d     = '0;
            state_d   = ACCESS;
          end else begin
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
            state_d   = RESP;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_ready) begin
          m_ready_d = 1'b1;
          m_rdata_d = s_we_q ? '0 : sel_rdata;
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          state_d   = RESP;
          for (int i = 0; i < NCH; i++) begin
            if (ch_q == IW'(i) && hit_q[i] != 16'hFFFF) hit_d[i] = hit_q[i] + 16'd1;
          end
        end else if (timeout_hit) begin
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        s_sel_d = '0;
        s_we_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NCH; i++) hit_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < NCH; i++) hit_q[i] <= hit_d[i];
    end
  end

  // Flatten the per-channel counters onto the output bus, ch0 in the LSBs.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NCH; i++) hit_cnt[i*16 +: 16] = hit_q[i];
  end

  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_bus_mmu_n.sv
// Bench for bus_mmu_n: four overlapping regions, directed corner cases then
// randomized traffic, checked against a region-table model and a response queue.
module tb_bus_mmu_n;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam logic [NCH*AW-1:0] BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NCH*AW-1:0] MASK = {32'hFFFFE000, 32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFF000};

  logic              clk;
  logic              rst_n;
  logic              m_req;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_ready;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic [NCH-1:0]    s_sel;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NCH-1:0]    s_ready;
  logic [NCH*DW-1:0] s_rdata;
  logic [NCH*16-1:0] hit_cnt;

  // Reference region table: ch0 0x0000-0x0FFF, ch1 0x1000-0x1FFF,
  // ch2 0x2000-0x200F, ch3 0x2000-0x3FFF (shadowed by ch2 where they overlap).
  logic [31:0] tb_base [NCH];
  logic [31:0] tb_mask [NCH];
  int          exp_hit [NCH];
  logic [DW:0] exp_q [$];
  int          n_checks;
  int          n_errors;

  bus_mmu_n #(
    .NCH(NCH), .AW(AW), .DW(DW),
    .REGION_BASE(BASE), .REGION_MASK(MASK), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .hit_cnt(hit_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output bit hit, output int ch,
                                 output logic [31:0] off);
    hit = 0; ch = 0; off = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit && ((a & tb_mask[i]) == (tb_base[i] & tb_mask[i]))) begin
        hit = 1; ch = i; off = a & ~tb_mask[i];
      end
    end
  endfunction

  task automatic check_hits();
    for (int i = 0; i < NCH; i++) check($sformatf("hit_cnt%0d", i), 64'(hit_cnt[i*16 +: 16]), 64'(exp_hit[i]));
  endtask

  // One transaction; entered and left at a negedge with the DUT in IDLE.
  // wt = ACCESS cycles before the slave pulses ready (>= TO means never).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int wt);
    bit          hit;
    int          ch;
    logic [31:0] off;
    int          exp_lat;
    int          sel_cycles;
    bit          got;
    logic [DW:0] e;
    decode(addr, hit, ch, off);
    exp_lat = !hit ? 1 : (wt < TO ? 2 + wt : TO + 1);
    if (!hit || wt >= TO) exp_q.push_back({1'b1, 32'h0});
    m_we = we; m_addr = addr; m_wdata = wd; m_req = 1'b1;
    sel_cycles = 0; got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (hit && c == 1) begin
        check("s_sel", 64'(s_sel), 64'(1 << ch));
        check("s_we", 64'(s_we), 64'(we));
        check("s_addr", 64'(s_addr), 64'(off));
        check("s_wdata", 64'(s_wdata), 64'(wd));
      end
      if (s_sel != 0) sel_cycles++;
      if (m_ready) begin
        got = 1;
        check("latency", 64'(c), 64'(exp_lat));
        if (exp_q.size() == 0) check("exp_q_empty", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("m_err", 64'(m_err), 64'(e[DW]));
          check("m_rdata", 64'(m_rdata), 64'(e[DW-1:0]));
        end
      end
      for (int i = 0; i < NCH; i++) s_rdata[i*DW +: DW] = $urandom;
      s_ready = NCH'($urandom);
      if (hit) begin
        s_ready[ch] = (c - 1 == wt);
        if (c - 1 == wt && wt < TO) exp_q.push_back({1'b0, we ? 32'h0 : s_rdata[ch*DW +: DW]});
      end
      if (c == 2 && $urandom_range(0, 1) == 1) m_req = 1'b0;
    end
    if (!got) begin
      check("no_response", 64'(0), 64'(1));
      exp_q.delete();
    end
    m_req = 1'b0;
    s_ready = '0;
    check("sel_cycles", 64'(sel_cycles), 64'(hit ? exp_lat - 1 : 0));
    if (hit && wt < TO && exp_hit[ch] < 65535) exp_hit[ch]++;
    check_hits();
    @(negedge clk);
    check("ready_one_cycle", 64'(m_ready), 64'(0));
  endtask

  initial begin
    logic [31:0] bases [6];
    n_checks = 0; n_errors = 0;
    tb_base[0] = 32'h0000; tb_mask[0] = 32'hFFFFF000;
    tb_base[1] = 32'h1000; tb_mask[1] = 32'hFFFFF000;
    tb_base[2] = 32'h2000; tb_mask[2] = 32'hFFFFFFF0;
    tb_base[3] = 32'h3000; tb_mask[3] = 32'hFFFFE000;
    for (int i = 0; i < NCH; i++) exp_hit[i] = 0;
    bases[0] = 32'h0000; bases[1] = 32'h1000; bases[2] = 32'h2000;
    bases[3] = 32'h3000; bases[4] = 32'h5000; bases[5] = 32'h2000_0000;

    // Reset
    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_ready", 64'(m_ready), 64'(0));
    check("rst_m_err", 64'(m_err), 64'(0));
    check("rst_m_rdata", 64'(m_rdata), 64'(0));
    check("rst_s_sel", 64'(s_sel), 64'(0));
    check("rst_s_we", 64'(s_we), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    check("rst_s_wdata", 64'(s_wdata), 64'(0));
    check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners
    do_txn(1'b0, 32'h0000_0104, 32'h0, 0);    // ch0, ready first cycle
    do_txn(1'b1, 32'h0000_2004, 32'h41, 3);   // ch2 write, 3 wait states
    do_txn(1'b0, 32'h0000_5000, 32'h0, 0);    // unmapped
    do_txn(1'b0, 32'h0000_1010, 32'h0, 99);   // ch1 never ready -> timeout
    do_txn(1'b0, 32'h0000_1000, 32'h0, TO-1); // ready on last allowed cycle
    do_txn(1'b0, 32'h0000_1000, 32'h0, TO);   // one cycle too late
    do_txn(1'b0, 32'h0000_2008, 32'h0, 1);    // overlap ch2/ch3 -> ch2
    do_txn(1'b1, 32'h0000_2010, 32'h77, 2);   // ch3 outside ch2 window

    // Reset in the middle of an access
    m_we = 1'b0; m_addr = 32'h0000_0100; m_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_s_sel", 64'(s_sel), 64'(0));
    check("midrst_m_ready", 64'(m_ready), 64'(0));
    check("midrst_hit_cnt", 64'(hit_cnt), 64'(0));
    m_req = 1'b0;
    for (int i = 0; i < NCH; i++) exp_hit[i] = 0;
    @(negedge clk);
    check("midrst_no_resp", 64'(m_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 32'h0000_0104, 32'h0, 1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          w;
      a = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 255));
      w = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
